// File: rtl/bias_pkg.sv
// +----------------------------------------------------------------------------+
// | bias_pkg : shared lane width and saturating add / ReLU helpers              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package bias_pkg;

    localparam int DATA_W = 18;
    localparam int SUM_W  = DATA_W + 1;

    // Sign-extended sum; one extra bit is enough to never wrap.
    function automatic logic [SUM_W-1:0] sext_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

    // Overflow shows up as the two top bits disagreeing; the top bit gives direction.
    function automatic logic [DATA_W-1:0] sat_add(input logic [SUM_W-1:0] s);
        logic [DATA_W-1:0] r;
        if (s[SUM_W-1] != s[SUM_W-2]) begin
            r = s[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            r = s[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v,
                                               input logic             en);
        return (en && v[DATA_W-1]) ? '0 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bias_lane.sv
// +----------------------------------------------------------------------------+
// | bias_lane : one combinational lane - add bias, saturate, optional ReLU      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bias_lane
    import bias_pkg::*;
(
    input  logic [DATA_W-1:0] sum,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic [DATA_W-1:0] result
);

    logic [SUM_W-1:0]  w_wide;
    logic [DATA_W-1:0] w_sat;

    assign w_wide = sext_add(sum, bias);
    assign w_sat  = sat_add(w_wide);
    assign result = relu(w_sat, relu_en);

endmodule

`default_nettype wire

// File: rtl/bias_add_seq.sv
// +----------------------------------------------------------------------------+
// | bias_add_seq : streaming per-channel bias add with writable bias table     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bias_add_seq #(
    parameter  int N_adder_tree = 16,
    parameter  int N_CH         = 64,
    parameter  int DATA_W       = bias_pkg::DATA_W,
    localparam int N_GRP        = N_CH / N_adder_tree,
    localparam int GRP_W        = (N_GRP > 1) ? $clog2(N_GRP) : 1,
    localparam int ADDR_W       = $clog2(N_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [ADDR_W-1:0]              cfg_addr,
    input  logic [DATA_W-1:0]              cfg_data,
    input  logic                           relu_en,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [N_adder_tree*DATA_W-1:0] s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [N_adder_tree*DATA_W-1:0] m_data,
    output logic [GRP_W-1:0]               m_grp,
    output logic                           m_last
);

    import bias_pkg::*;

    localparam logic [GRP_W-1:0] c_last_grp = GRP_W'(N_GRP - 1);

    logic [DATA_W-1:0]              r_bias [N_CH];
    logic [GRP_W-1:0]               r_grp;
    logic                           r_valid;
    logic [N_adder_tree*DATA_W-1:0] r_data;
    logic [GRP_W-1:0]               r_out_grp;
    logic                           r_last;

    logic                           w_accept;
    logic                           w_addr_ok;
    logic [N_adder_tree*DATA_W-1:0] w_lane_out;

    assign s_ready   = ~r_valid | m_ready;
    assign w_accept  = s_valid & s_ready;
    assign w_addr_ok = (32'(cfg_addr) < 32'(N_CH));

    // Table is deliberately left out of reset so it survives a mid-stream rst.
    always_ff @(posedge clk) begin
        if (cfg_we && w_addr_ok) begin
            r_bias[cfg_addr] <= cfg_data;
        end
    end

    generate
        for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
            logic [ADDR_W-1:0] w_idx;
            assign w_idx = ADDR_W'(32'(r_grp) * N_adder_tree + i);

            bias_lane u_lane (
                .sum     (s_data[DATA_W*i +: DATA_W]),
                .bias    (r_bias[w_idx]),
                .relu_en (relu_en),
                .result  (w_lane_out[DATA_W*i +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp <= '0;
        end else if (w_accept) begin
            r_grp <= (r_grp == c_last_grp) ? '0 : r_grp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_out_grp <= '0;
            r_last    <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_data    <= w_lane_out;
            r_out_grp <= r_grp;
            r_last    <= (r_grp == c_last_grp);
        end else if (m_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_grp   = r_out_grp;
    assign m_last  = r_last;

endmodule

`default_nettype wire
